// File: rtl/alu_ctrl_pkg.sv
// ALU control codes and the sharing-arbiter state encoding.
package alu_ctrl_pkg;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_MUL = 6'b011000;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_NOR = 6'b100111;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SLL = 6'b000000;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] ALU_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to
// whichever requester was not granted last.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (&valid_i) grant_o = last_i ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the EX operate path (req 0) and the branch/compare
// unit (req 1): round-robin accept, registered operands, tagged response.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int CTRL_W     = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [CTRL_W-1:0] Req0Ctrl,
    input  logic [31:0]       Req0A,
    input  logic [31:0]       Req0B,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [CTRL_W-1:0] Req1Ctrl,
    input  logic [31:0]       Req1A,
    input  logic [31:0]       Req1B,
    output logic              RspValid,
    input  logic              RspReady,
    output logic              RspId,
    output logic [31:0]       RspResult,
    output logic              RspZero,
    output logic [CTRL_W-1:0] AluControl,
    output logic [31:0]       AluA,
    output logic [31:0]       AluB,
    input  logic [31:0]       AluResult,
    input  logic              AluZero
);

    // A zero multiply latency is clamped so the counter always has a cycle to run.
    localparam int MC    = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
    localparam int CNT_W = $clog2(MC + 1);
    localparam logic [CTRL_W-1:0] MUL_CODE = CTRL_W'(ALU_MUL);

    state_e            state_q, state_d;
    logic [1:0]        grant;
    logic              accept, sel, done;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       res_q, res_d;
    logic              zero_q, zero_d, id_q, id_d;
    logic              tag_q, tag_d, last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_arbiter2 u_rr (
        .valid_i ({Req1Valid, Req0Valid}),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign sel      = grant[1];
    assign sel_ctrl = sel ? Req1Ctrl : Req0Ctrl;
    assign accept   = (state_q == ST_IDLE) && (|grant);
    assign done     = (state_q == ST_EXEC) && (cnt_q == CNT_W'(1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|grant)   state_d = ST_EXEC;
            ST_EXEC: if (done)     state_d = ST_RESP;
            ST_RESP: if (RspReady) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Ready is also masked by reset so nothing looks accepted while held in reset.
    always_comb begin
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        RspValid  = (state_q == ST_RESP);
        if (state_q == ST_IDLE && Reset) begin
            Req0Ready = grant[0];
            Req1Ready = grant[1];
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        a_d    = a_q;
        b_d    = b_q;
        tag_d  = tag_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        zero_d = zero_q;
        id_d   = id_q;
        if (accept) begin
            ctrl_d = sel_ctrl;
            a_d    = sel ? Req1A : Req0A;
            b_d    = sel ? Req1B : Req0B;
            tag_d  = sel;
            last_d = sel;
            cnt_d  = (sel_ctrl == MUL_CODE) ? CNT_W'(MC) : CNT_W'(1);
        end else if (done) begin
            res_d  = AluResult;
            zero_d = AluZero;
            id_d   = tag_q;
        end else if (state_q == ST_EXEC) begin
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag_q  <= 1'b0;
            last_q <= 1'b1;
            cnt_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            id_q   <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            a_q    <= a_d;
            b_q    <= b_d;
            tag_q  <= tag_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            id_q   <= id_d;
        end
    end

    // The ALU keeps seeing the last operands after the op completes.
    assign AluControl = ctrl_q;
    assign AluA       = a_q;
    assign AluB       = b_q;
    assign RspResult  = res_q;
    assign RspZero    = zero_q;
    assign RspId      = id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU beside the DUT, directed scenarios
// and a randomized run checked against a transaction-level reference model.
module tb_alu_share_arbiter;
    import alu_ctrl_pkg::*;

    localparam int MC = 3;

    logic        Clk = 1'b0, Reset = 1'b0;
    logic        Req0Valid, Req0Ready, Req1Valid, Req1Ready;
    logic [5:0]  Req0Ctrl, Req1Ctrl, AluControl;
    logic [31:0] Req0A, Req0B, Req1A, Req1B, RspResult, AluA, AluB, AluResult;
    logic        RspValid, RspReady, RspId, RspZero, AluZero;
    int tests = 0, fails = 0;

    alu_share_arbiter #(.MUL_CYCLES(MC), .CTRL_W(6)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Ctrl(Req0Ctrl), .Req0A(Req0A), .Req0B(Req0B),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Ctrl(Req1Ctrl), .Req1A(Req1A), .Req1B(Req1B),
        .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId), .RspResult(RspResult), .RspZero(RspZero),
        .AluControl(AluControl), .AluA(AluA), .AluB(AluB), .AluResult(AluResult), .AluZero(AluZero)
    );

    always #5 Clk = ~Clk;

    // Behavioural ALU: {Zero, Result}; unknown codes give Result 0, Zero 1.
    function automatic logic [32:0] alu_ref(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_MUL: r = a * b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_NOR: r = ~(a | b);
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {AluZero, AluResult} = alu_ref(AluControl, AluA, AluB);

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic clear_inputs();
        Req0Valid = 0; Req0Ctrl = '0; Req0A = '0; Req0B = '0;
        Req1Valid = 0; Req1Ctrl = '0; Req1A = '0; Req1B = '0;
        RspReady = 1'b1;
    endtask

    task automatic apply_reset();
        Reset = 1'b0;
        clear_inputs();
        repeat (2) tick();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1'b0;
        Req0Valid = 1; Req1Valid = 1; Req0A = 32'hFFFF_FFFF;
        repeat (2) tick();
        tests++; if ({Req0Ready, Req1Ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", {Req0Ready, Req1Ready}); end
        tests++; if ({RspValid, RspId, RspZero} !== 3'b000) begin fails++; $display("FAIL reset_rsp_flags: got %b want 000", {RspValid, RspId, RspZero}); end
        tests++; if (RspResult !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want 0", RspResult); end
        tests++; if ({AluControl, AluA, AluB} !== 70'd0) begin fails++; $display("FAIL reset_alu_drive: got %h %h %h want 0", AluControl, AluA, AluB); end
        clear_inputs();
        Reset = 1'b1;
        #1;
        tests++; if ({Req0Ready, Req1Ready, RspValid} !== 3'b000) begin fails++; $display("FAIL reset_idle_quiet: got %b want 000", {Req0Ready, Req1Ready, RspValid}); end
    endtask

    task automatic test_single_add();
        apply_reset();
        Req0Valid = 1; Req0Ctrl = ALU_ADD; Req0A = 32'd5; Req0B = 32'd7;
        #1;
        tests++; if ({Req0Ready, Req1Ready} !== 2'b10) begin fails++; $display("FAIL add_ready: got %b want 10", {Req0Ready, Req1Ready}); end
        tick();
        Req0Valid = 0;
        #1;
        tests++; if (RspValid !== 1'b0) begin fails++; $display("FAIL add_exec_rspvalid: got %b want 0", RspValid); end
        tests++; if ({AluControl, AluA, AluB} !== {ALU_ADD, 32'd5, 32'd7}) begin fails++; $display("FAIL add_alu_drive: got %h %0d %0d want %h 5 7", AluControl, AluA, AluB, ALU_ADD); end
        tick();
        tests++; if (RspValid !== 1'b1) begin fails++; $display("FAIL add_rspvalid: got %b want 1", RspValid); end
        tests++; if ({RspId, RspZero, RspResult} !== {1'b0, 1'b0, 32'd12}) begin fails++; $display("FAIL add_rsp: got id %b z %b r %0d want 0 0 12", RspId, RspZero, RspResult); end
        tick();
        tests++; if (RspValid !== 1'b0) begin fails++; $display("FAIL add_rsp_drop: got %b want 0", RspValid); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        Req0Valid = 1; Req0Ctrl = ALU_SUB; Req0A = 32'd9;   Req0B = 32'd9;
        Req1Valid = 1; Req1Ctrl = ALU_OR;  Req1A = 32'hF0;  Req1B = 32'h0F;
        #1;
        tests++; if ({Req0Ready, Req1Ready} !== 2'b10) begin fails++; $display("FAIL sim_first_grant: got %b want 10", {Req0Ready, Req1Ready}); end
        tick();
        Req0Valid = 0;
        tick();
        tests++; if ({RspValid, RspId, RspZero, RspResult} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin fails++; $display("FAIL sim_rsp0: got v %b id %b z %b r %h want 1 0 1 0", RspValid, RspId, RspZero, RspResult); end
        tests++; if (Req1Ready !== 1'b0) begin fails++; $display("FAIL sim_busy_ready1: got %b want 0", Req1Ready); end
        tick();
        tests++; if (Req1Ready !== 1'b1) begin fails++; $display("FAIL sim_second_grant: got %b want 1", Req1Ready); end
        tick();
        Req1Valid = 0;
        tick();
        tests++; if ({RspValid, RspId, RspZero, RspResult} !== {1'b1, 1'b1, 1'b0, 32'hFF}) begin fails++; $display("FAIL sim_rsp1: got v %b id %b z %b r %h want 1 1 0 ff", RspValid, RspId, RspZero, RspResult); end
        tick();
    endtask

    task automatic test_multiply();
        apply_reset();
        Req0Valid = 1; Req0Ctrl = ALU_MUL; Req0A = 32'd6; Req0B = 32'd7;
        tick();
        Req0Valid = 0;
        for (int i = 0; i < MC; i++) begin
            tests++; if ({RspValid, AluControl, AluA, AluB} !== {1'b0, ALU_MUL, 32'd6, 32'd7}) begin fails++; $display("FAIL mul_hold_%0d: got v %b c %h a %0d b %0d want 0 18 6 7", i, RspValid, AluControl, AluA, AluB); end
            tick();
        end
        tests++; if ({RspValid, RspResult} !== {1'b1, 32'd42}) begin fails++; $display("FAIL mul_rsp: got v %b r %0d want 1 42", RspValid, RspResult); end
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        RspReady = 1'b0;
        Req0Valid = 1; Req0Ctrl = ALU_ADD; Req0A = 32'd3; Req0B = 32'd4;
        tick();
        Req0Valid = 0;
        Req1Valid = 1; Req1Ctrl = ALU_ADD; Req1A = 32'd10; Req1B = 32'd20;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++; if ({RspValid, RspId, RspResult, Req1Ready} !== {1'b1, 1'b0, 32'd7, 1'b0}) begin fails++; $display("FAIL bp_hold_%0d: got v %b id %b r %0d rdy1 %b want 1 0 7 0", i, RspValid, RspId, RspResult, Req1Ready); end
            tests++; if ({AluA, AluB} !== {32'd3, 32'd4}) begin fails++; $display("FAIL bp_alu_%0d: got %0d %0d want 3 4", i, AluA, AluB); end
            tick();
        end
        RspReady = 1'b1;
        tick();
        tests++; if ({RspValid, Req1Ready} !== 2'b01) begin fails++; $display("FAIL bp_req1_ready: got v %b rdy1 %b want 0 1", RspValid, Req1Ready); end
        tick();
        Req1Valid = 0;
        tick();
        tests++; if ({RspValid, RspId, RspResult} !== {1'b1, 1'b1, 32'd30}) begin fails++; $display("FAIL bp_rsp1: got v %b id %b r %0d want 1 1 30", RspValid, RspId, RspResult); end
        tick();
    endtask

    task automatic test_fairness();
        logic        g;
        logic [32:0] exp;
        int          k;
        apply_reset();
        Req0Valid = 1; Req0Ctrl = ALU_ADD; Req0A = $urandom; Req0B = $urandom;
        Req1Valid = 1; Req1Ctrl = ALU_ADD; Req1A = $urandom; Req1B = $urandom;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            #1;
            while (!(Req0Ready || Req1Ready) && k < 10) begin tick(); #1; k++; end
            g = Req1Ready;
            tests++; if (k >= 10 || g !== n[0]) begin fails++; $display("FAIL fair_grant_%0d: got %b (waited %0d) want %0d", n, g, k, n % 2); end
            exp = g ? alu_ref(ALU_ADD, Req1A, Req1B) : alu_ref(ALU_ADD, Req0A, Req0B);
            tick();
            if (g) begin Req1A = $urandom; Req1B = $urandom; end
            else   begin Req0A = $urandom; Req0B = $urandom; end
            k = 0;
            while (!RspValid && k < 10) begin tick(); k++; end
            tests++; if (!RspValid || RspId !== g || RspResult !== exp[31:0]) begin fails++; $display("FAIL fair_rsp_%0d: got v %b id %b r %h want 1 %b %h", n, RspValid, RspId, RspResult, g, exp[31:0]); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_mul();
        apply_reset();
        Req0Valid = 1; Req0Ctrl = ALU_MUL; Req0A = 32'd6; Req0B = 32'd7;
        tick();
        Req0Valid = 0;
        Req1Valid = 1; Req1Ctrl = ALU_ADD; Req1A = 32'd1; Req1B = 32'd1;
        tick();
        Reset = 1'b0;
        #1;
        tests++; if ({AluControl, AluA, AluB} !== 70'd0) begin fails++; $display("FAIL rstmul_alu: got %h %h %h want 0", AluControl, AluA, AluB); end
        tests++; if ({RspValid, RspId, RspZero, RspResult, Req0Ready, Req1Ready} !== 37'd0) begin fails++; $display("FAIL rstmul_outputs: got v %b id %b z %b r %h rdy %b%b want all 0", RspValid, RspId, RspZero, RspResult, Req0Ready, Req1Ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (RspValid !== 1'b0) begin fails++; $display("FAIL rstmul_norsp_%0d: got %b want 0", i, RspValid); end
        end
        Reset = 1'b1;
        #1;
        tests++; if ({RspValid, Req1Ready} !== 2'b01) begin fails++; $display("FAIL rstmul_resume: got v %b rdy1 %b want 0 1", RspValid, Req1Ready); end
        tick();
        Req1Valid = 0;
        tick();
        tests++; if ({RspValid, RspId, RspResult} !== {1'b1, 1'b1, 32'd2}) begin fails++; $display("FAIL rstmul_add: got v %b id %b r %0d want 1 1 2", RspValid, RspId, RspResult); end
        tick();
    endtask

    // Transaction-level model: a granted op answers lat cycles after its accept
    // edge and the ALU is busy until the response handshake.
    task automatic test_random();
        logic [5:0]  codes [11] = '{ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_NOR,
                                    ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT, 6'b111111};
        logic        pv [2];
        logic [5:0]  pc [2];
        logic [31:0] pa [2], pb [2];
        logic        busy, last, exp_rv, op_id;
        logic [1:0]  exp_g;
        logic [5:0]  op_c;
        logic [31:0] op_a, op_b;
        logic [32:0] exp;
        int          rsp_at;
        apply_reset();
        busy = 0; last = 1; rsp_at = 0; op_id = 0; op_c = '0; op_a = '0; op_b = '0;
        pv[0] = 0; pv[1] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 1) == 1) begin
                    pv[r] = 1;
                    pc[r] = codes[$urandom_range(0, 10)];
                    pa[r] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                    pb[r] = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom;
                end
            end
            Req0Valid = pv[0]; Req0Ctrl = pc[0]; Req0A = pa[0]; Req0B = pb[0];
            Req1Valid = pv[1]; Req1Ctrl = pc[1]; Req1A = pa[1]; Req1B = pb[1];
            RspReady  = ($urandom_range(0, 3) != 0);
            #1;
            exp_g = 2'b00;
            if (!busy) begin
                if (pv[0] && pv[1]) exp_g = last ? 2'b01 : 2'b10;
                else                exp_g = {pv[1], pv[0]};
            end
            tests++; if ({Req1Ready, Req0Ready} !== exp_g) begin fails++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, {Req1Ready, Req0Ready}, exp_g); end
            exp_rv = busy && (cyc >= rsp_at);
            tests++; if (RspValid !== exp_rv) begin fails++; $display("FAIL rnd_rspvalid@%0d: got %b want %b", cyc, RspValid, exp_rv); end
            if (exp_rv) begin
                exp = alu_ref(op_c, op_a, op_b);
                tests++; if ({RspId, RspZero, RspResult} !== {op_id, exp}) begin fails++; $display("FAIL rnd_rsp@%0d: got id %b z %b r %h want %b %b %h", cyc, RspId, RspZero, RspResult, op_id, exp[32], exp[31:0]); end
            end else if (busy) begin
                tests++; if ({AluControl, AluA, AluB} !== {op_c, op_a, op_b}) begin fails++; $display("FAIL rnd_alu@%0d: got %h %h %h want %h %h %h", cyc, AluControl, AluA, AluB, op_c, op_a, op_b); end
            end
            if (exp_rv && RspReady) begin
                busy = 0;
            end else if (exp_g != 2'b00) begin
                op_id  = exp_g[1];
                op_c   = pc[op_id]; op_a = pa[op_id]; op_b = pb[op_id];
                busy   = 1;
                last   = op_id;
                rsp_at = cyc + 1 + ((op_c == ALU_MUL) ? MC : 1);
                pv[op_id] = 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_add();
        test_simultaneous();
        test_multiply();
        test_backpressure();
        test_fairness();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single 32-bit ALU between two requesters: requester 0 is the EX-stage operate path and requester 1 is the branch/compare unit. It grants the ALU round-robin, registers the operands, and drives the ALU control and operand inputs. It waits a fixed number of cycles for multiply operations, then returns the result with a tag on a valid/ready response channel. The ALU is instantiated beside this block at the datapath top and connected through the `Alu*` ports.

## Interface
- `MUL_CYCLES`, default 3: cycles the ALU inputs are held for a multiply (control 6'b011000). Must be ≥1; a value of 0 is treated as 1.
- `CTRL_W`, default 6: width of the ALU control field.

- `Clk` in 1: the single clock.
- `Reset` in 1: asynchronous, active-low reset.
- `Req0Valid` in 1: requester 0 has an operation pending.
- `Req0Ready` out 1: requester 0 is accepted this cycle.
- `Req0Ctrl` in CTRL_W: ALU control code for requester 0.
- `Req0A` in 32: operand A for requester 0.
- `Req0B` in 32: operand B for requester 0.
- `Req1Valid`, `Req1Ready`, `Req1Ctrl`, `Req1A`, `Req1B`: same as requester 0, for requester 1.
- `RspValid` out 1: the response is valid.
- `RspReady` in 1: the consumer accepts the response.
- `RspId` out 1: index of the requester that owns the response.
- `RspResult` out 32: captured ALU result.
- `RspZero` out 1: captured ALU Zero flag.
- `AluControl` out CTRL_W: drives the ALU control input.
- `AluA` out 32: drives ALU operand A.
- `AluB` out 32: drives ALU operand B.
- `AluResult` in 32: ALU result.
- `AluZero` in 1: ALU Zero flag.

## Operation
- The state machine has three states: IDLE, EXEC and RESP.
- **IDLE**
  - With one requester valid, that requester is granted.
  - With both valid, the requester other than `LastGrant` is granted.
  - `ReqXReady` = (state==IDLE) & grant==X. It is combinational from the valids and has one-hot or zero behaviour.
  - On Valid&Ready, the arbiter:
    - latches Ctrl, A and B into the operand registers;
    - sets `LastGrant`=X and the tag to X;
    - loads the counter with MUL_CYCLES when Ctrl==MUL, otherwise with 1;
    - moves to EXEC.
- **EXEC**
  - `AluControl`, `AluA` and `AluB` are driven from the operand registers.
  - The counter decrements each cycle.
  - In the cycle the counter is 1, `AluResult` and `AluZero` are captured into the response registers and the state moves to RESP.
- **RESP**
  - `RspValid`=1. `RspResult`, `RspZero` and `RspId` are stable.
  - On RspValid&RspReady the state returns to IDLE.
  - No new accept happens in the same cycle; both Ready outputs are 0 outside IDLE.
- Control codes are not decoded apart from MUL detection; any code is forwarded unchanged. An unknown code returns the ALU's default (Result 0, Zero 1).
- Requesters hold Valid, Ctrl, A and B stable until Ready. The arbiter samples them only in the accept cycle.
- **Reset values**
  - State IDLE and `LastGrant`=1, so Req0 wins the first contest.
  - All outputs are 0: Ready, RspValid, RspId, RspResult, RspZero, AluControl, AluA, AluB.
  - Operand registers and counter are 0.

## Timing
- Accept occurs at edge t, with Ready high in cycle t-1.
- Non-MUL: EXEC in cycle t, RspValid from cycle t+1.
- MUL: EXEC in cycles t..t+MUL_CYCLES-1, RspValid from cycle t+MUL_CYCLES.
- Throughput is at most one operation per 3 cycles (non-MUL, RspReady held high).
- Backpressure: RESP holds indefinitely with all response outputs frozen. The ALU drive outputs keep the last operands.
- Simultaneous new requests while busy are ignored until IDLE. Arbitration uses the valids present in the IDLE cycle only.
- Reset asserted mid-EXEC or mid-RESP:
  - All outputs clear asynchronously.
  - The in-flight operation is discarded and no response is produced.
  - After release, operation resumes from IDLE with `LastGrant`=1.
- Counter width is $clog2(MUL_CYCLES+1). It never wraps below 1 in EXEC.

## Structure
- The shared package `alu_ctrl_pkg` holds:
  - the ALU control constants (ADD 6'b100000, SUB 6'b100010, MUL 6'b011000, AND 6'b100100, OR 6'b100101, NOR 6'b100111, XOR 6'b100110, SLL 6'b000000, SRL 6'b000010, SLT 6'b101010);
  - the state encoding (IDLE, EXEC, RESP).
- One natural sub-module is `rr_arbiter2`: two-input round-robin grant. Its inputs are the two valids and `LastGrant`; its output is a one-hot grant.

## Test plan
- **Single ADD:** Req0 ADD A=5, B=7, RspReady=1 → Req0Ready high in the first IDLE cycle, RspValid 2 cycles later, Result 12, Zero 0, Id 0.
- **Simultaneous requests after reset:** Req0 SUB 9,9 and Req1 OR 0xF0,0x0F → Req0 served first (Result 0, Zero 1, Id 0), then Req1 (Result 0xFF, Zero 0, Id 1).
- **Multiply:** MUL 6×7 with MUL_CYCLES=3 → AluA/AluB held 3 cycles, RspValid 3 cycles after the accept edge, Result 42.
- **Backpressure:** RspReady low for 5 cycles with Req1 valid → RspValid, Result and Id stable, Req1Ready stays 0, Req1 accepted 1 cycle after the response handshake.
- **Fairness:** both requesters held valid for 4 operations → grant order 0, 1, 0, 1, with Ids matching.
- **Reset during multiply:** Reset low in the 2nd MUL EXEC cycle → all outputs 0 immediately, no response; after release, ADD 1+1 from Req1 returns 2 with Id 1.
